// File: rtl/ratio_fifo.sv
// ratio_fifo: width-converting FIFO, one RATIO-slice wide write in,
// one narrow entry out per read, most-significant slice first.
//
// Ports:
//   clk      sole clock, rising edge
//   reset_n  asynchronous active-low reset
//   wr       write request, accepted when !full
//   w_data   RATIO*DATA_WIDTH write word, slice 0 in the MS bits
//   rd       read request, accepted when !empty
//   r_data   head entry, combinational (fall-through)
//   empty    no entries stored
//   full     fewer than RATIO free entries
//   count    entries stored, 0..2**ADDR_WIDTH
//   err      sticky misuse flag, only with RATIO_FIFO_ERR_EN defined
//
// Option macro: RATIO_FIFO_ERR_EN adds the err port and its logic.
module ratio_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int RATIO      = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        wr,
  input  logic [RATIO*DATA_WIDTH-1:0] w_data,
  input  logic                        rd,
  output logic [DATA_WIDTH-1:0]       r_data,
  output logic                        empty,
  output logic                        full,
  output logic [ADDR_WIDTH:0]         count
`ifdef RATIO_FIFO_ERR_EN
  ,
  output logic                        err
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [ADDR_WIDTH:0] DEPTH_C =
    (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] RATIO_C =
    (ADDR_WIDTH+1)'(RATIO);
  // RATIO == DEPTH truncates to 0: the pointer wraps back onto itself.
  localparam logic [ADDR_WIDTH-1:0] STEP =
    ADDR_WIDTH'(RATIO);
  localparam logic [ADDR_WIDTH:0] ONE_C =
    (ADDR_WIDTH+1)'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wp;
  logic [ADDR_WIDTH-1:0] rp;
  logic [ADDR_WIDTH:0]   free_cnt;
  logic                  wr_ok;
  logic                  rd_ok;
  logic [ADDR_WIDTH:0]   count_nxt;

  // Flags come only from registered count.
  assign free_cnt = DEPTH_C - count;
  assign empty    = (count == '0);
  assign full     = (free_cnt < RATIO_C);

  // A same-cycle read never frees room for the write.
  assign wr_ok = wr & ~full;
  assign rd_ok = rd & ~empty;

  always_comb begin
    count_nxt = count;
    if (wr_ok)
      count_nxt = count_nxt + RATIO_C;
    if (rd_ok)
      count_nxt = count_nxt - ONE_C;
  end

  assign r_data = mem[rp];

  // wp stays RATIO-aligned, so wp+k never crosses the wrap.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      for (int k = 0; k < RATIO; k++) begin
        mem[wp + ADDR_WIDTH'(k)] <=
          w_data[(RATIO-k)*DATA_WIDTH-1 -: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (wr_ok)
        wp <= wp + STEP;
      if (rd_ok)
        rp <= rp + 1'b1;
      count <= count_nxt;
    end
  end

`ifdef RATIO_FIFO_ERR_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      err <= 1'b0;
    else if ((wr & full) | (rd & empty))
      err <= 1'b1;
  end
`endif

endmodule
